// File: rtl/ascon_linear_seq_pkg.sv
// rtl/ascon_linear_seq_pkg.sv - shared types, rotation tables and helpers for the Ascon linear layer
package ascon_linear_seq_pkg;

  localparam int LANE_W  = 64;
  localparam int N_LANES = 5;
  localparam int STATE_W = N_LANES * LANE_W;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ROT_A [N_LANES] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [N_LANES] = '{28, 39, 6, 17, 41};

  // A shift of LANE_W or more yields zero, so n == 0 degenerates cleanly to x.
  function automatic lane_t ror64(input lane_t x, input int n);
    int s;
    s = n % LANE_W;
    return (x >> s) | (x << (LANE_W - s));
  endfunction

endpackage

// File: rtl/ascon_linear_seq_if.sv
// rtl/ascon_linear_seq_if.sv - valid/ready handshake bundle for the Ascon linear layer
interface ascon_linear_seq_if;
  import ascon_linear_seq_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/ascon_linear_seq_lane_diffuse.sv
// rtl/ascon_linear_seq_lane_diffuse.sv - one-lane combinational diffusion y = x ^ ror(x,a) ^ ror(x,b)
module ascon_linear_seq_lane_diffuse
  import ascon_linear_seq_pkg::*;
(
  input  lane_t      x,
  input  logic [5:0] rot_a,
  input  logic [5:0] rot_b,
  output lane_t      y
);

  assign y = x ^ ror64(x, int'(rot_a)) ^ ror64(x, int'(rot_b));

endmodule

// File: rtl/ascon_linear_seq.sv
// rtl/ascon_linear_seq.sv - folded, handshaked Ascon p_L over the 320-bit state
module ascon_linear_seq
  import ascon_linear_seq_pkg::*;
#(
  parameter int LANES_PER_CYCLE = 5,
  parameter int LANE_W          = 64
) (
  input logic clk,
  input logic rst_n,
  ascon_linear_seq_if.slave bus
);

  localparam int         LPC      = LANES_PER_CYCLE;
  localparam logic [2:0] LAST_IDX = 3'(N_LANES - LPC);
  localparam logic [2:0] IDX_STEP = 3'(LPC);

  if (LPC != 1 && LPC != 5) begin : g_bad_lpc
    $error("ascon_linear_seq: LANES_PER_CYCLE must be 1 or 5");
  end
  if (LANE_W != 64) begin : g_bad_lane_w
    $error("ascon_linear_seq: LANE_W must be 64");
  end

  state_t             state_q, state_d;
  logic [2:0]         lane_idx_q, lane_idx_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic [STATE_W-1:0] st_diff;

  lane_t      dx [LPC];
  logic [5:0] ra [LPC];
  logic [5:0] rb [LPC];
  lane_t      dy [LPC];

  for (genvar g = 0; g < LPC; g++) begin : g_diff
    ascon_linear_seq_lane_diffuse u_diff (
      .x     (dx[g]),
      .rot_a (ra[g]),
      .rot_b (rb[g]),
      .y     (dy[g])
    );
  end

  if (LPC == 1) begin : g_fold
    // One shared diffuser; lane and rotation pair selected by lane_idx.
    always_comb begin
      dx[0] = '0;
      ra[0] = '0;
      rb[0] = '0;
      for (int i = 0; i < N_LANES; i++) begin
        if (lane_idx_q == 3'(i)) begin
          dx[0] = st_q[STATE_W-1-64*i -: 64];
          ra[0] = 6'(ROT_A[i]);
          rb[0] = 6'(ROT_B[i]);
        end
      end
    end

    always_comb begin
      st_diff = st_q;
      for (int i = 0; i < N_LANES; i++) begin
        if (lane_idx_q == 3'(i)) begin
          st_diff[STATE_W-1-64*i -: 64] = dy[0];
        end
      end
    end
  end else begin : g_full
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      assign dx[g] = st_q[STATE_W-1-64*g -: 64];
      assign ra[g] = 6'(ROT_A[g]);
      assign rb[g] = 6'(ROT_B[g]);
    end

    always_comb begin
      st_diff = '0;
      for (int i = 0; i < N_LANES; i++) begin
        st_diff[STATE_W-1-64*i -: 64] = dy[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      st_q       <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      st_q       <= st_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lane_idx_d    = lane_idx_q;
    st_d          = st_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_state = '0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          st_d       = bus.in_state;
          lane_idx_d = '0;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        st_d = st_diff;
        if (lane_idx_q == LAST_IDX) begin
          lane_idx_d = '0;
          state_d    = DONE;
        end else begin
          lane_idx_d = lane_idx_q + IDX_STEP;
        end
      end

      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_state = st_q;
        // Accepting straight from DONE avoids an IDLE bubble when streaming.
        if (bus.out_ready) begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            st_d       = bus.in_state;
            lane_idx_d = '0;
            state_d    = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        lane_idx_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_linear_seq.sv
// tb/tb_ascon_linear_seq.sv - directed bench for ascon_linear_seq at LANES_PER_CYCLE 1 and 5
module tb_ascon_linear_seq;

  logic clk;
  logic rst1;
  logic rst5;
  int   n_chk;
  int   n_err;

  ascon_linear_seq_if b1 ();
  ascon_linear_seq_if b5 ();

  ascon_linear_seq #(.LANES_PER_CYCLE(1), .LANE_W(64)) dut1 (
    .clk   (clk),
    .rst_n (rst1),
    .bus   (b1)
  );

  ascon_linear_seq #(.LANES_PER_CYCLE(5), .LANE_W(64)) dut5 (
    .clk   (clk),
    .rst_n (rst5),
    .bus   (b5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int TA [5] = '{19, 61, 1, 10, 7};
  localparam int TB [5] = '{28, 39, 6, 17, 41};

  localparam logic [319:0] V_ZERO = '0;
  localparam logic [319:0] V_ONES = '1;
  localparam logic [319:0] V_BIT  = {64'h1, 64'h0, 64'h1, 64'h0, 64'h1};
  localparam logic [319:0] E_BIT  = {64'h0000_2010_0000_0001, 64'h0,
                                     64'h8400_0000_0000_0001, 64'h0,
                                     64'h0200_0000_0080_0001};
  localparam logic [319:0] V_PAT  = {5{64'h0123_4567_89ab_cdef}};

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] model(input logic [319:0] s);
    logic [319:0] r;
    logic [63:0]  x;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      x = s[319-64*i -: 64];
      r[319-64*i -: 64] = x ^ rr(x, TA[i]) ^ rr(x, TB[i]);
    end
    return r;
  endfunction

  function automatic logic get_ir(input int sel);
    return (sel == 1) ? b1.in_ready : b5.in_ready;
  endfunction

  function automatic logic get_ov(input int sel);
    return (sel == 1) ? b1.out_valid : b5.out_valid;
  endfunction

  function automatic logic [319:0] get_os(input int sel);
    return (sel == 1) ? b1.out_state : b5.out_state;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [319:0] s);
    if (sel == 1) begin
      b1.in_valid = v;
      b1.in_state = s;
    end else begin
      b5.in_valid = v;
      b5.in_state = s;
    end
  endtask

  task automatic set_rdy(input int sel, input logic r);
    if (sel == 1) b1.out_ready = r;
    else          b5.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_vec(output logic [319:0] v);
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
  endtask

  // Latency counts the accept cycle as cycle 1, up to the first out_valid cycle.
  task automatic run_vec(input int sel, input logic [319:0] v, input logic [319:0] e,
                         input string tag);
    int n;
    n = 0;
    set_in(sel, 1'b1, v);
    while (!get_ir(sel) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_acc"}, 320'(get_ir(sel)), 320'(1));
    tick();
    set_in(sel, 1'b0, '0);
    n = 1;
    while (!get_ov(sel) && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 320'(n), 320'(1 + 5 / sel));
    chk({tag, "_data"}, get_os(sel), e);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [319:0] v;
    logic [319:0] vs [3];
    int           t [3];
    int           idx;
    int           k;
    int           n;
    int           sel;
    logic         take;

    n_chk = 0;
    n_err = 0;
    rst1 = 1'b0;
    rst5 = 1'b0;
    set_in(1, 1'b0, '0);
    set_in(5, 1'b0, '0);
    set_rdy(1, 1'b1);
    set_rdy(5, 1'b1);
    repeat (2) tick();

    for (int p = 0; p < 2; p++) begin
      sel = (p == 0) ? 1 : 5;
      chk($sformatf("l%0d_rst_ov", sel), 320'(get_ov(sel)), 320'(0));
      chk($sformatf("l%0d_rst_os", sel), get_os(sel), '0);
    end
    rst1 = 1'b1;
    rst5 = 1'b1;
    tick();

    for (int p = 0; p < 2; p++) begin
      sel = (p == 0) ? 1 : 5;
      chk($sformatf("l%0d_rst_ir", sel), 320'(get_ir(sel)), 320'(1));

      run_vec(sel, V_ZERO, '0,    $sformatf("l%0d_zero", sel));
      run_vec(sel, V_ONES, '1,    $sformatf("l%0d_ones", sel));
      run_vec(sel, V_BIT,  E_BIT, $sformatf("l%0d_bit", sel));

      // Backpressure: hold result for 10 cycles while a new vector waits.
      set_rdy(sel, 1'b0);
      set_in(sel, 1'b1, V_PAT);
      tick();
      set_in(sel, 1'b1, V_BIT);
      n = 0;
      while (!get_ov(sel) && n < 20) begin
        tick();
        n++;
      end
      for (int c = 0; c < 10; c++) begin
        tick();
        chk($sformatf("l%0d_bp_os%0d", sel, c), get_os(sel), model(V_PAT));
        chk($sformatf("l%0d_bp_ov%0d", sel, c), 320'(get_ov(sel)), 320'(1));
        chk($sformatf("l%0d_bp_ir%0d", sel, c), 320'(get_ir(sel)), 320'(0));
      end
      set_rdy(sel, 1'b1);
      #1;
      chk($sformatf("l%0d_bp_ir_rel", sel), 320'(get_ir(sel)), 320'(1));
      tick();
      set_in(sel, 1'b0, '0);
      n = 0;
      while (!get_ov(sel) && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("l%0d_bp_next", sel), get_os(sel), E_BIT);
      tick();

      // Back-to-back streaming of three vectors.
      vs[0] = V_ONES;
      vs[1] = V_PAT;
      vs[2] = V_BIT;
      idx = 0;
      k = 0;
      set_in(sel, 1'b1, vs[0]);
      for (int c = 0; c < 60 && k < 3; c++) begin
        take = get_ir(sel);
        tick();
        if (take) begin
          idx++;
          if (idx < 3) set_in(sel, 1'b1, vs[idx]);
          else         set_in(sel, 1'b0, '0);
        end
        if (get_ov(sel)) begin
          chk($sformatf("l%0d_b2b_data%0d", sel, k), get_os(sel), model(vs[k]));
          t[k] = c;
          k++;
        end
      end
      set_in(sel, 1'b0, '0);
      chk($sformatf("l%0d_b2b_count", sel), 320'(k), 320'(3));
      if (k == 3) begin
        chk($sformatf("l%0d_b2b_gap0", sel), 320'(t[1] - t[0]), 320'(1 + 5 / sel));
        chk($sformatf("l%0d_b2b_gap1", sel), 320'(t[2] - t[1]), 320'(1 + 5 / sel));
      end
      tick();

      for (int r = 0; r < 3; r++) begin
        rand_vec(v);
        run_vec(sel, v, model(v), $sformatf("l%0d_rand%0d", sel, r));
      end
    end

    // Reset while the folded build is mid-way through the lanes.
    rand_vec(v);
    set_in(1, 1'b1, v);
    tick();
    set_in(1, 1'b0, '0);
    tick();
    tick();
    chk("l1_mid_idx", 320'(dut1.lane_idx_q), 320'(2));
    rst1 = 1'b0;
    #1;
    chk("l1_mid_rst_ov", 320'(b1.out_valid), 320'(0));
    chk("l1_mid_rst_os", b1.out_state, '0);
    tick();
    rst1 = 1'b1;
    tick();
    chk("l1_mid_rel_ir", 320'(b1.in_ready), 320'(1));
    rand_vec(v);
    run_vec(1, v, model(v), "l1_after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
